// File: rtl/flash_read_arbiter_if.sv
// Bundle between the two flash read clients, the arbiter and the flash Avalon-MM read port.
// The arbiter takes the slave modport; the side that drives requests and models the flash takes master.
interface flash_read_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic [1:0]          req_read;
    logic [2*ADDR_W-1:0] req_address;
    logic [1:0]          req_waitrequest;
    logic [2*DATA_W-1:0] req_readdata;
    logic [1:0]          req_readdatavalid;
    logic                flash_mem_read;
    logic [ADDR_W-1:0]   flash_mem_address;
    logic                flash_mem_waitrequest;
    logic [DATA_W-1:0]   flash_mem_readdata;
    logic                flash_mem_readdatavalid;
    logic                timeout_err;

    modport slave (
        input  req_read, req_address,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output flash_mem_read, flash_mem_address, timeout_err
    );

    modport master (
        output req_read, req_address,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  flash_mem_read, flash_mem_address, timeout_err
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing the flash Avalon-MM read port between two clients,
// one read outstanding at a time, with a watchdog that answers with zero data if the flash goes silent.
module flash_read_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    flash_read_arbiter_if.slave   bus
);

    localparam int TIMER_W = $clog2(TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } arbState_t;

    arbState_t            r_state;
    logic                 r_lastGrant;
    logic                 r_owner;
    logic                 r_flashRead;
    logic [ADDR_W-1:0]    r_flashAddr;
    logic [TIMER_W-1:0]   r_timer;
    logic [2*DATA_W-1:0]  r_rdData;
    logic [1:0]           r_rdValid;
    logic                 r_timeoutErr;

    logic                 w_accept;
    logic                 w_ownerSel;
    logic [1:0]           w_grantMask;
    logic [ADDR_W-1:0]    w_selAddr;
    logic [TIMER_W-1:0]   w_timerNext;
    logic                 w_timeout;

    // Nothing is accepted while reset is held, so stalled clients see waitrequest = req_read.
    assign w_accept = (r_state == IDLE) && !reset && (|bus.req_read);

    always_comb begin
        w_ownerSel = 1'b0;
        if (bus.req_read == 2'b10)
            w_ownerSel = 1'b1;
        else if (bus.req_read == 2'b11)
            w_ownerSel = ~r_lastGrant;
    end

    assign w_grantMask = w_accept ? (w_ownerSel ? 2'b10 : 2'b01) : 2'b00;
    assign w_selAddr   = w_ownerSel ? bus.req_address[ADDR_W +: ADDR_W]
                                    : bus.req_address[0 +: ADDR_W];

    // Saturating watchdog; fires on the increment that reaches TIMEOUT-1.
    assign w_timerNext = (r_timer == {TIMER_W{1'b1}}) ? r_timer : r_timer + TIMER_W'(1);
    assign w_timeout   = (w_timerNext >= TIMER_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lastGrant  <= 1'b1;
            r_owner      <= 1'b0;
            r_flashRead  <= 1'b0;
            r_flashAddr  <= '0;
            r_timer      <= '0;
            r_rdData     <= '0;
            r_rdValid    <= 2'b00;
            r_timeoutErr <= 1'b0;
        end else begin
            r_rdValid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner     <= w_ownerSel;
                        r_lastGrant <= w_ownerSel;
                        r_flashAddr <= w_selAddr;
                        r_flashRead <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.flash_mem_waitrequest) begin
                        r_flashRead <= 1'b0;
                        r_timer     <= '0;
                        r_state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    r_timer <= w_timerNext;
                    if (bus.flash_mem_readdatavalid || w_timeout) begin
                        if (r_owner) begin
                            r_rdData[DATA_W +: DATA_W] <= bus.flash_mem_readdatavalid ? bus.flash_mem_readdata : '0;
                            r_rdValid <= 2'b10;
                        end else begin
                            r_rdData[0 +: DATA_W] <= bus.flash_mem_readdatavalid ? bus.flash_mem_readdata : '0;
                            r_rdValid <= 2'b01;
                        end
                        if (!bus.flash_mem_readdatavalid)
                            r_timeoutErr <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_waitrequest   = bus.req_read & ~w_grantMask;
    assign bus.req_readdata      = r_rdData;
    assign bus.req_readdatavalid = r_rdValid;
    assign bus.flash_mem_read    = r_flashRead;
    assign bus.flash_mem_address = r_flashAddr;
    assign bus.timeout_err       = r_timeoutErr;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: single reads, round-robin ties, flash stalls,
// watchdog expiry and reset during an outstanding read, with TIMEOUT shortened to 16.
module tb_flash_read_arbiter;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    flash_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    flash_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1ns after the rising edge and outputs are checked 1ns later.
    task automatic applyStimulus(input logic [1:0] rd, input logic fwait, input logic fvalid, input logic [31:0] fdata);
        @(posedge clk);
        #1;
        bus.req_read                = rd;
        bus.flash_mem_waitrequest   = fwait;
        bus.flash_mem_readdatavalid = fvalid;
        bus.flash_mem_readdata      = fdata;
        #1;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_read = 2'b00;
        bus.flash_mem_readdatavalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Called in the accept cycle with both ports requesting; zero-wait flash, data two cycles after accept.
    task automatic rrRead(input string name, input logic [1:0] expWait, input logic [22:0] expAddr,
                          input logic [31:0] data, input logic [1:0] expValid, input logic [63:0] expData,
                          input logic [1:0] rdLast);
        checkOutput({name, " accept waitrequest"}, 64'(bus.req_waitrequest), 64'(expWait));
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput({name, " issue read"}, 64'(bus.flash_mem_read), 64'd1);
        checkOutput({name, " issue address"}, 64'(bus.flash_mem_address), 64'(expAddr));
        checkOutput({name, " issue waitrequest"}, 64'(bus.req_waitrequest), 64'd3);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput({name, " wait read low"}, 64'(bus.flash_mem_read), 64'd0);
        applyStimulus(2'b11, 1'b0, 1'b1, data);
        checkOutput({name, " no early strobe"}, 64'(bus.req_readdatavalid), 64'd0);
        applyStimulus(rdLast, 1'b0, 1'b0, 32'h0);
        checkOutput({name, " strobe"}, 64'(bus.req_readdatavalid), 64'(expValid));
        checkOutput({name, " readdata"}, bus.req_readdata, expData);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_read                = 2'b00;
        bus.req_address             = '0;
        bus.flash_mem_waitrequest   = 1'b0;
        bus.flash_mem_readdata      = '0;
        bus.flash_mem_readdatavalid = 1'b0;

        // Reset state, with both clients requesting and being held off.
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput("reset waitrequest", 64'(bus.req_waitrequest), 64'd3);
        checkOutput("reset flash read", 64'(bus.flash_mem_read), 64'd0);
        checkOutput("reset flash address", 64'(bus.flash_mem_address), 64'd0);
        checkOutput("reset readdata", bus.req_readdata, 64'd0);
        checkOutput("reset strobe", 64'(bus.req_readdatavalid), 64'd0);
        checkOutput("reset timeout_err", 64'(bus.timeout_err), 64'd0);
        bus.req_read = 2'b00;
        reset = 1'b0;

        // Single read on port 0, N=2.
        bus.req_address = {23'h000555, 23'h000010};
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
        checkOutput("single accept", 64'(bus.req_waitrequest), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("single issue read", 64'(bus.flash_mem_read), 64'd1);
        checkOutput("single issue address", 64'(bus.flash_mem_address), 64'h10);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("single read drops", 64'(bus.flash_mem_read), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("single no early strobe", 64'(bus.req_readdatavalid), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("single strobe", 64'(bus.req_readdatavalid), 64'd1);
        checkOutput("single readdata", bus.req_readdata, 64'h00000000_DEADBEEF);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("single strobe one cycle", 64'(bus.req_readdatavalid), 64'd0);
        checkOutput("single readdata held", bus.req_readdata, 64'h00000000_DEADBEEF);

        // Round robin: both request continuously, order must be 0,1,0,1.
        applyReset();
        bus.req_address = {23'h000200, 23'h000100};
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput("rr readdata after reset", bus.req_readdata, 64'd0);
        rrRead("rr1", 2'b10, 23'h000100, 32'h11111111, 2'b01, 64'h00000000_11111111, 2'b11);
        rrRead("rr2", 2'b01, 23'h000200, 32'h22222222, 2'b10, 64'h22222222_11111111, 2'b11);
        rrRead("rr3", 2'b10, 23'h000100, 32'h33333333, 2'b01, 64'h22222222_33333333, 2'b11);
        rrRead("rr4", 2'b01, 23'h000200, 32'h44444444, 2'b10, 64'h44444444_33333333, 2'b00);

        // Flash stall on a port 1 read while port 0 waits.
        bus.req_address = {23'h000300, 23'h000100};
        applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
        checkOutput("stall accept", 64'(bus.req_waitrequest), 64'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b01, (i < 5) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            checkOutput("stall read held", 64'(bus.flash_mem_read), 64'd1);
            checkOutput("stall address held", 64'(bus.flash_mem_address), 64'h300);
            checkOutput("stall other port waits", 64'(bus.req_waitrequest), 64'd1);
        end
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
        checkOutput("stall read drops", 64'(bus.flash_mem_read), 64'd0);
        applyStimulus(2'b01, 1'b0, 1'b1, 32'h55AA55AA);
        checkOutput("stall still waiting", 64'(bus.req_waitrequest), 64'd1);
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
        checkOutput("stall strobe", 64'(bus.req_readdatavalid), 64'd2);
        checkOutput("stall readdata", bus.req_readdata, 64'h55AA55AA_33333333);
        checkOutput("timeout accept", 64'(bus.req_waitrequest), 64'd0);

        // Watchdog: the port 0 read just accepted never gets data.
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("timeout issue read", 64'(bus.flash_mem_read), 64'd1);
        checkOutput("timeout issue address", 64'(bus.flash_mem_address), 64'h100);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
            checkOutput("timeout no early strobe", 64'(bus.req_readdatavalid), 64'd0);
            checkOutput("timeout flag not yet", 64'(bus.timeout_err), 64'd0);
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("timeout strobe", 64'(bus.req_readdatavalid), 64'd1);
        checkOutput("timeout zero data", bus.req_readdata, 64'h55AA55AA_00000000);
        checkOutput("timeout flag set", 64'(bus.timeout_err), 64'd1);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hBAD0BAD0);
        checkOutput("late valid strobe low", 64'(bus.req_readdatavalid), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("late valid ignored", 64'(bus.req_readdatavalid), 64'd0);
        checkOutput("late valid data untouched", bus.req_readdata, 64'h55AA55AA_00000000);
        checkOutput("timeout flag sticky", 64'(bus.timeout_err), 64'd1);
        checkOutput("idle read low", 64'(bus.flash_mem_read), 64'd0);

        // Reset while waiting for data.
        applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
        checkOutput("abort accept", 64'(bus.req_waitrequest), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("abort issue read", 64'(bus.flash_mem_read), 64'd1);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_read = 2'b11;
        #1;
        checkOutput("abort flash read", 64'(bus.flash_mem_read), 64'd0);
        checkOutput("abort flash address", 64'(bus.flash_mem_address), 64'd0);
        checkOutput("abort readdata", bus.req_readdata, 64'd0);
        checkOutput("abort strobe", 64'(bus.req_readdatavalid), 64'd0);
        checkOutput("abort timeout_err cleared", 64'(bus.timeout_err), 64'd0);
        checkOutput("abort waitrequest in reset", 64'(bus.req_waitrequest), 64'd3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_read = 2'b00;
        bus.flash_mem_readdatavalid = 1'b1;
        bus.flash_mem_readdata = 32'h00000BAD;
        #1;
        checkOutput("abort late valid strobe low", 64'(bus.req_readdatavalid), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("abort late valid ignored", 64'(bus.req_readdatavalid), 64'd0);
        checkOutput("abort late data ignored", bus.req_readdata, 64'd0);
        bus.req_address = {23'h000200, 23'h000400};
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        rrRead("post", 2'b10, 23'h000400, 32'h77777777, 2'b01, 64'h00000000_77777777, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish within 200000 ns");
        $fatal(1, "[TB] bench timed out");
    end

endmodule
